// File: rtl/wash_phase_timer.sv
// wash_phase_timer: level debounce, wash/spin phase timers and fill watchdog feeding the washer controller
module wash_phase_timer #(
  parameter int CLKS_PER_TICK = 1000,
  parameter int CYCLE_TICKS = 600,
  parameter int SPIN_TICKS = 300,
  parameter int FULL_LEVEL = 200,
  parameter int EMPTY_LEVEL = 10,
  parameter int DEBOUNCE = 4,
  parameter int FILL_MAX_CLKS = 600000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  Water_Level,
  input  logic        Motor_on,
  input  logic        Fill_valve_on,
  input  logic        Drained_valve_on,
  input  logic        Door_Lock,
  output logic        Filled,
  output logic        Drained,
  output logic        Cycle_Timeout,
  output logic        Spin_Timeout,
  output logic [15:0] Time_Left,
  output logic        Fault
);
  localparam int PW = $clog2(CLKS_PER_TICK + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int WW = $clog2(FILL_MAX_CLKS + 1);
  typedef enum logic [2:0] {IDLE, WASH, WASH_DONE, DRAIN_WAIT, SPIN, SPIN_DONE} state_t;
  state_t state, nxt;
  logic [PW-1:0] pre;
  logic [DW-1:0] fc, ec;
  logic [WW-1:0] wd;
  logic [15:0] tl_nxt;
  logic raw_full, raw_empty, run, tick, fill_run;
  assign raw_full = int'(Water_Level) >= FULL_LEVEL;
  assign raw_empty = int'(Water_Level) <= EMPTY_LEVEL;
  assign run = state == WASH || state == SPIN;
  assign tick = run && pre == PW'(CLKS_PER_TICK - 1);
  assign fill_run = Fill_valve_on && !Filled;
  assign Cycle_Timeout = state == WASH_DONE;
  assign Spin_Timeout = state == SPIN_DONE;
  always_comb begin
    nxt = state;
    tl_nxt = 16'd0;
    if (state != IDLE && !Door_Lock) nxt = IDLE;
    else case (state)
      IDLE:       nxt = Motor_on ? WASH : IDLE;
      WASH:       nxt = !Motor_on ? IDLE : (tick && Time_Left == 16'd1) ? WASH_DONE : WASH;
      WASH_DONE:  nxt = Motor_on ? WASH_DONE : DRAIN_WAIT;
      DRAIN_WAIT: nxt = (Drained_valve_on && Drained) ? SPIN : DRAIN_WAIT;
      SPIN:       nxt = !Drained_valve_on ? IDLE : (tick && Time_Left == 16'd1) ? SPIN_DONE : SPIN;
      SPIN_DONE:  nxt = Drained_valve_on ? SPIN_DONE : IDLE;
      default:    nxt = IDLE;
    endcase
    // load on phase entry, count down while staying in a timed phase, zero elsewhere
    tl_nxt = (state == IDLE && nxt == WASH) ? 16'(CYCLE_TICKS) :
             (state == DRAIN_WAIT && nxt == SPIN) ? 16'(SPIN_TICKS) :
             (run && nxt == state) ? Time_Left - {15'd0, tick && Time_Left != 16'd0} : 16'd0;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Time_Left <= 16'd0;
      pre <= '0;
    end else begin
      state <= nxt;
      Time_Left <= tl_nxt;
      pre <= (run && nxt == state) ? (tick ? '0 : pre + 1'b1) : '0;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Filled <= 1'b0;
      Drained <= 1'b1;
      fc <= '0;
      ec <= '0;
      wd <= '0;
      Fault <= 1'b0;
    end else begin
      fc <= (raw_full != Filled && fc != DW'(DEBOUNCE - 1)) ? fc + 1'b1 : '0;
      ec <= (raw_empty != Drained && ec != DW'(DEBOUNCE - 1)) ? ec + 1'b1 : '0;
      if (raw_full != Filled && fc == DW'(DEBOUNCE - 1)) Filled <= raw_full;
      if (raw_empty != Drained && ec == DW'(DEBOUNCE - 1)) Drained <= raw_empty;
      wd <= !fill_run ? '0 : (wd == WW'(FILL_MAX_CLKS)) ? wd : wd + 1'b1;
      Fault <= Fault || (fill_run && wd == WW'(FILL_MAX_CLKS - 1));
    end
  end
endmodule

// File: tb/tb_wash_phase_timer.sv
// tb_wash_phase_timer: phase/elapsed-time model plus directed vectors with literal expectations
module tb_wash_phase_timer;
  localparam int CPT = 4, CYC = 3, SPN = 2, FULL = 200, EMPTY = 10, DB = 3, FMAX = 50;
  localparam int P_IDLE = 0, P_WASH = 1, P_WDONE = 2, P_DWAIT = 3, P_SPIN = 4, P_SDONE = 5;
  logic clk = 0, rst = 1;
  logic [7:0] lvl = 0;
  logic motor = 0, fill = 0, dv = 0, door = 0;
  logic filled, drained, cyc_to, spin_to, fault;
  logic [15:0] tl;
  int checks = 0, passed = 0;
  int m_phase, m_el, m_wd;
  bit m_filled, m_drained, m_fault, m_valid = 0;
  bit hf[$], he[$];

  wash_phase_timer #(.CLKS_PER_TICK(CPT), .CYCLE_TICKS(CYC), .SPIN_TICKS(SPN), .FULL_LEVEL(FULL),
    .EMPTY_LEVEL(EMPTY), .DEBOUNCE(DB), .FILL_MAX_CLKS(FMAX)) dut (
    .Clock(clk), .Reset(rst), .Water_Level(lvl), .Motor_on(motor), .Fill_valve_on(fill),
    .Drained_valve_on(dv), .Door_Lock(door), .Filled(filled), .Drained(drained),
    .Cycle_Timeout(cyc_to), .Spin_Timeout(spin_to), .Time_Left(tl), .Fault(fault));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
  endtask

  function automatic bit all_differ(input bit q[$], input bit v);
    if (q.size() < DB) return 0;
    foreach (q[i]) if (q[i] == v) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE; m_el = 0; m_filled = 0; m_drained = 1; m_wd = 0; m_fault = 0;
      hf.delete(); he.delete(); m_valid = 1;
    end else begin
      if (m_phase != P_IDLE && !door) m_phase = P_IDLE;
      else case (m_phase)
        P_IDLE: if (motor) begin m_phase = P_WASH; m_el = 0; end
        P_WASH: if (!motor) m_phase = P_IDLE;
                else begin m_el++; if (m_el == CYC * CPT) m_phase = P_WDONE; end
        P_WDONE: if (!motor) m_phase = P_DWAIT;
        P_DWAIT: if (dv && m_drained) begin m_phase = P_SPIN; m_el = 0; end
        P_SPIN: if (!dv) m_phase = P_IDLE;
                else begin m_el++; if (m_el == SPN * CPT) m_phase = P_SDONE; end
        default: if (!dv) m_phase = P_IDLE;
      endcase
      m_wd = (fill && !m_filled) ? m_wd + 1 : 0;
      if (m_wd >= FMAX) m_fault = 1;
      hf.push_back(lvl >= FULL); he.push_back(lvl <= EMPTY);
      if (hf.size() > DB) begin void'(hf.pop_front()); void'(he.pop_front()); end
      if (all_differ(hf, m_filled)) m_filled = !m_filled;
      if (all_differ(he, m_drained)) m_drained = !m_drained;
    end
  end

  always @(negedge clk) if (m_valid) begin
    chk("filled", filled, m_filled);
    chk("drained", drained, m_drained);
    chk("cycle_timeout", cyc_to, m_phase == P_WDONE);
    chk("spin_timeout", spin_to, m_phase == P_SDONE);
    chk("time_left", tl, m_phase == P_WASH ? CYC - m_el / CPT : m_phase == P_SPIN ? SPN - m_el / CPT : 0);
    chk("fault", fault, m_fault);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(2);
    chk("lit_reset_drained", drained, 1); chk("lit_reset_filled", filled, 0);
    chk("lit_reset_tl", tl, 0); chk("lit_reset_fault", fault, 0);
    rst = 0;
    lvl = 220;
    step(2); chk("lit_filled_early", filled, 0); chk("lit_drained_early", drained, 1);
    step(1); chk("lit_filled_rise", filled, 1); chk("lit_drained_fall", drained, 0);
    repeat (4) begin lvl = 0; step(2); lvl = 220; step(2); end
    chk("lit_toggle_filled", filled, 1); chk("lit_toggle_drained", drained, 0);
    door = 1; motor = 1;
    step(1); chk("lit_wash_tl3", tl, 3);
    step(4); chk("lit_wash_tl2", tl, 2);
    step(4); chk("lit_wash_tl1", tl, 1);
    step(3); chk("lit_cyc_before", cyc_to, 0);
    step(1); chk("lit_cyc_rise", cyc_to, 1); chk("lit_cyc_tl0", tl, 0);
    motor = 0;
    step(1); chk("lit_cyc_fall", cyc_to, 0);
    dv = 1; lvl = 5;
    step(4); chk("lit_spin_tl2", tl, 2); chk("lit_spin_drained", drained, 1);
    step(7); chk("lit_spin_before", spin_to, 0);
    step(1); chk("lit_spin_rise", spin_to, 1);
    dv = 0;
    step(1); chk("lit_spin_fall", spin_to, 0); chk("lit_spin_idle_tl", tl, 0);
    motor = 1;
    step(5); chk("lit_abort_tl2", tl, 2);
    door = 0;
    step(1); chk("lit_abort_tl0", tl, 0);
    motor = 0;
    step(15); chk("lit_abort_no_cyc", cyc_to, 0);
    fill = 1; lvl = 50;
    step(49); chk("lit_fault_before", fault, 0);
    step(1); chk("lit_fault_set", fault, 1);
    fill = 0;
    step(3); chk("lit_fault_sticky", fault, 1);
    rst = 1;
    step(1); chk("lit_fault_reset", fault, 0); chk("lit_reset_drained2", drained, 1);
    rst = 0; lvl = 5; door = 1; motor = 1;
    step(1); chk("lit_wash2_tl3", tl, 3);
    step(12); chk("lit_cyc2_rise", cyc_to, 1);
    motor = 0;
    step(1); dv = 1;
    step(1); chk("lit_spin2_tl2", tl, 2);
    step(8); chk("lit_spin2_rise", spin_to, 1);
    rst = 1;
    step(1);
    chk("lit_rst_sd_filled", filled, 0); chk("lit_rst_sd_drained", drained, 1);
    chk("lit_rst_sd_cyc", cyc_to, 0); chk("lit_rst_sd_spin", spin_to, 0);
    chk("lit_rst_sd_tl", tl, 0); chk("lit_rst_sd_fault", fault, 0);
    rst = 0; dv = 0; motor = 1;
    step(1); chk("lit_wash3_tl3", tl, 3);
    step(11); chk("lit_cyc3_before", cyc_to, 0);
    step(1); chk("lit_cyc3_rise", cyc_to, 1);
    motor = 0;
    step(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
- Sensor-and-timer front end that feeds the washing-machine control FSM.
- Consumes the controller's actuator outputs (Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock) and a raw water-level reading.
- Produces the controller's status inputs: Filled, Drained, Cycle_Timeout, Spin_Timeout.
- Adds a fill watchdog Fault flag and a remaining-time readout.

Parameters:
- CLKS_PER_TICK, 1000: clocks per timer tick (1 s at 1 kHz).
- CYCLE_TICKS, 600: wash duration in ticks; must be ≥1 and < 2^16.
- SPIN_TICKS, 300: spin duration in ticks; must be ≥1 and < 2^16.
- FULL_LEVEL, 200: raw level at or above which the tub counts as full.
- EMPTY_LEVEL, 10: raw level at or below which the tub counts as empty.
- DEBOUNCE, 4: consecutive clocks a raw comparison must hold before Filled/Drained change.
- FILL_MAX_CLKS, 600000: maximum continuous Fill_valve_on clocks without Filled before Fault.

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high; one clock, one reset, no other clock domains
- Water_Level  in  8  unsigned raw level sensor, sampled every clock
- Motor_on  in  1  from controller
- Fill_valve_on  in  1  from controller
- Drained_valve_on  in  1  from controller
- Door_Lock  in  1  from controller
- Filled  out  1  debounced level ≥ FULL_LEVEL
- Drained  out  1  debounced level ≤ EMPTY_LEVEL
- Cycle_Timeout  out  1  wash time expired
- Spin_Timeout  out  1  spin time expired
- Time_Left  out  16  ticks remaining in current WASH/SPIN; 0 otherwise
- Fault  out  1  sticky fill-watchdog error

Behaviour:
- Reset (synchronous, any state, mid-operation included), all registered:
  - FSM → IDLE; prescaler, tick counter and watchdog → 0.
  - Filled=0, Drained=1, Cycle_Timeout=0, Spin_Timeout=0, Time_Left=0, Fault=0.
- Level debounce, independent of the FSM:
  - raw_full = (Water_Level ≥ FULL_LEVEL); raw_empty = (Water_Level ≤ EMPTY_LEVEL).
  - Each output flips only after its raw compare has differed from the current output for DEBOUNCE consecutive clocks; a run counter restarts on any mismatch break.
  - Filled and Drained are never both 1.
- Prescaler:
  - Counts 0..CLKS_PER_TICK-1 only in WASH and SPIN.
  - Cleared to 0 on the entry edge of either state; tick = (prescaler == CLKS_PER_TICK-1).
- FSM states and transitions (evaluated each rising edge; abort rule has priority over all else):
  - Abort: in any state other than IDLE, Door_Lock=0 → IDLE, Time_Left=0, timeouts cleared.
  - IDLE: Motor_on=1 → WASH, Time_Left loaded with CYCLE_TICKS.
  - WASH: on tick, Time_Left decrements. On a tick with Time_Left==1 → WASH_DONE and Time_Left=0. Motor_on=0 before expiry → IDLE.
  - WASH_DONE: Cycle_Timeout=1 (Moore, registered). Motor_on=0 → DRAIN_WAIT.
  - DRAIN_WAIT: Drained_valve_on=1 and Drained=1 → SPIN, Time_Left loaded with SPIN_TICKS.
  - SPIN: tick decrement as in WASH; on a tick with Time_Left==1 → SPIN_DONE. Drained_valve_on=0 before expiry → IDLE.
  - SPIN_DONE: Spin_Timeout=1. Drained_valve_on=0 → IDLE.
- Latency:
  - Cycle_Timeout rises exactly CYCLE_TICKS×CLKS_PER_TICK clocks after the WASH entry edge.
  - Spin_Timeout rises exactly SPIN_TICKS×CLKS_PER_TICK clocks after the SPIN entry edge.
  - Each timeout falls on the edge after the controller drops Motor_on / Drained_valve_on; with the Mealy controller this makes each a 1-cycle pulse.
- Fill watchdog:
  - Counter increments each clock while Fill_valve_on=1 and Filled=0; clears otherwise (saturating).
  - Reaching FILL_MAX_CLKS sets Fault; Fault stays set until Reset.
  - Fault does not alter FSM or timer behaviour.
- Arithmetic: Time_Left is 16-bit and never underflows (decrement gated by Time_Left≠0).

Test Plan (CLKS_PER_TICK=4, CYCLE_TICKS=3, SPIN_TICKS=2, DEBOUNCE=3, FILL_MAX_CLKS=50):
1. Reset, then Water_Level 0→220 held → Drained falls and Filled rises exactly 3 clocks after the level change; Water_Level toggling 220/0 every 2 clocks → neither output changes.
2. Door_Lock=1, Motor_on=1 at edge E → Time_Left 3,2,1; Cycle_Timeout=1 at E+12; drop Motor_on at E+12 → Cycle_Timeout=0 at E+13, FSM in DRAIN_WAIT.
3. From DRAIN_WAIT: Drained_valve_on=1, Water_Level=5 (Drained=1) → SPIN entered at edge S; Spin_Timeout=1 at S+8; Drained_valve_on=0 → IDLE, Time_Left=0.
4. Door_Lock=0 mid-WASH at Time_Left=2 → next edge IDLE, Time_Left=0; Cycle_Timeout never asserts.
5. Fill_valve_on=1, Water_Level=50 held 50 clocks → Fault=1 and stays 1 after Fill_valve_on drops; Reset → Fault=0.
6. Reset asserted in SPIN_DONE → next edge all outputs at reset values (Drained=1); a following Motor_on=1 restarts the full 12-clock wash.
